muldiv_seq_unit: RTL and testbench

- Parametrised multi-cycle multiply/divide unit with HI/LO registers. It is the sequential successor to the combinational ALU control decode.
- Decodes R-type mult/multu/div/divu/mfhi/mflo/mthi/mtlo from the ALU op and function field.
- Runs iterative shift-add multiply and restoring divide over WIDTH cycles.
- Sits beside the main ALU in the execute stage and raises stall to the pipeline while busy.

---
 rtl/muldiv_seq_unit.sv | 180 ++++++++++++++++++
 tb/tb_muldiv_seq_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq_unit.sv
// Sequential multiply/divide unit with HI/LO registers for the execute stage.
// Shift-add multiply and restoring divide share one 2*WIDTH accumulator; sign fix-up runs in a final cycle.
module muldiv_seq_unit #(
   parameter int              WIDTH    = 32,
   parameter int              OP_W     = 4,
   parameter int              FN_W     = 6,
   parameter logic [OP_W-1:0] RTYPE_OP = 4'b1000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [OP_W-1:0]  alu_op,
   input  logic [FN_W-1:0]  fn_field,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] mf_data,
   output logic             busy,
   output logic             done,
   output logic             stall
);

   // state  | meaning
   // S_IDLE | waiting; mult/div accepted, mthi/mtlo written here
   // S_CALC | one shift-add or restore-subtract step per cycle, cnt_q counts down
   // S_FIX  | sign correction, HI/LO write, done pulse
   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

   localparam int CW = $clog2(WIDTH);
   localparam logic [FN_W-1:0] FN_MFHI  = FN_W'(6'b010000);
   localparam logic [FN_W-1:0] FN_MTHI  = FN_W'(6'b010001);
   localparam logic [FN_W-1:0] FN_MFLO  = FN_W'(6'b010010);
   localparam logic [FN_W-1:0] FN_MTLO  = FN_W'(6'b010011);
   localparam logic [FN_W-1:0] FN_MULT  = FN_W'(6'b011000);
   localparam logic [FN_W-1:0] FN_MULTU = FN_W'(6'b011001);
   localparam logic [FN_W-1:0] FN_DIV   = FN_W'(6'b011010);
   localparam logic [FN_W-1:0] FN_DIVU  = FN_W'(6'b011011);

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     opnd_q, opnd_d;
   logic [WIDTH-1:0]     raw_a_q, raw_a_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic                 is_div_q, is_div_d;
   logic                 neg_q_q, neg_q_d;
   logic                 neg_r_q, neg_r_d;
   logic                 dz_q, dz_d;
   logic                 done_q, done_d;

   logic is_rt;
   logic dec_mult, dec_multu, dec_div, dec_divu;
   logic dec_mfhi, dec_mflo, dec_mthi, dec_mtlo;
   logic dec_calc, dec_divide, dec_any;
   logic sa, sb;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     add_sum, sub_diff;
   logic [2*WIDTH-1:0] prod_neg;

   assign is_rt      = (alu_op == RTYPE_OP);
   assign dec_mult   = is_rt && (fn_field == FN_MULT);
   assign dec_multu  = is_rt && (fn_field == FN_MULTU);
   assign dec_div    = is_rt && (fn_field == FN_DIV);
   assign dec_divu   = is_rt && (fn_field == FN_DIVU);
   assign dec_mfhi   = is_rt && (fn_field == FN_MFHI);
   assign dec_mflo   = is_rt && (fn_field == FN_MFLO);
   assign dec_mthi   = is_rt && (fn_field == FN_MTHI);
   assign dec_mtlo   = is_rt && (fn_field == FN_MTLO);
   assign dec_divide = dec_div | dec_divu;
   assign dec_calc   = dec_mult | dec_multu | dec_divide;
   assign dec_any    = dec_calc | dec_mfhi | dec_mflo | dec_mthi | dec_mtlo;

   // Signed ops run on magnitudes; MIN negates to itself, which is the correct unsigned magnitude.
   assign sa    = (dec_mult | dec_div) & src_a[WIDTH-1];
   assign sb    = (dec_mult | dec_div) & src_b[WIDTH-1];
   assign mag_a = sa ? -src_a : src_a;
   assign mag_b = sb ? -src_b : src_b;

   assign add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
   assign sub_diff = acc_q[2*WIDTH-2:WIDTH-1] - {1'b0, opnd_q};
   assign prod_neg = -acc_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      raw_a_d  = raw_a_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      is_div_d = is_div_q;
      neg_q_d  = neg_q_q;
      neg_r_d  = neg_r_q;
      dz_d     = dz_q;
      done_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start && dec_calc) begin
               state_d  = S_CALC;
               cnt_d    = CW'(WIDTH-1);
               is_div_d = dec_divide;
               opnd_d   = dec_divide ? mag_b : mag_a;
               acc_d    = {{WIDTH{1'b0}}, (dec_divide ? mag_a : mag_b)};
               neg_q_d  = sa ^ sb;
               neg_r_d  = sa;
               raw_a_d  = src_a;
               dz_d     = dec_divide && (src_b == '0);
            end else if (start && dec_mthi) begin
               hi_d = src_a;
            end else if (start && dec_mtlo) begin
               lo_d = src_a;
            end
         end
         S_CALC: begin
            if (is_div_q) begin
               acc_d = sub_diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                       : {sub_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
               acc_d = {add_sum, acc_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) state_d = S_FIX;
         end
         S_FIX: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            if (!is_div_q) begin
               {hi_d, lo_d} = neg_q_q ? prod_neg : acc_q;
            end else if (dz_q) begin
               hi_d = raw_a_q;
               lo_d = '1;
            end else begin
               lo_d = neg_q_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
               hi_d = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         raw_a_q  <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         is_div_q <= 1'b0;
         neg_q_q  <= 1'b0;
         neg_r_q  <= 1'b0;
         dz_q     <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         raw_a_q  <= raw_a_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         is_div_q <= is_div_d;
         neg_q_q  <= neg_q_d;
         neg_r_q  <= neg_r_d;
         dz_q     <= dz_d;
         done_q   <= done_d;
      end
   end

   assign hi      = hi_q;
   assign lo      = lo_q;
   assign done    = done_q;
   assign busy    = (state_q != S_IDLE);
   assign stall   = start & busy & dec_any;
   assign mf_data = dec_mfhi ? hi_q : (dec_mflo ? lo_q : '0);

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Self-checking bench for muldiv_seq_unit: expected HI/LO from a behavioural model go into a
// queue at issue and are compared when done pulses; latency, stall, mf_data and reset checked directly.
module tb_muldiv_seq_unit;

   localparam logic [3:0] RT       = 4'b1000;
   localparam logic [5:0] FN_MFHI  = 6'b010000;
   localparam logic [5:0] FN_MTHI  = 6'b010001;
   localparam logic [5:0] FN_MFLO  = 6'b010010;
   localparam logic [5:0] FN_MTLO  = 6'b010011;
   localparam logic [5:0] FN_MULT  = 6'b011000;
   localparam logic [5:0] FN_MULTU = 6'b011001;
   localparam logic [5:0] FN_DIV   = 6'b011010;
   localparam logic [5:0] FN_DIVU  = 6'b011011;
   localparam logic [5:0] FN_ADD   = 6'b100000;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [3:0]  alu_op;
   logic [5:0]  fn_field;
   logic [31:0] src_a, src_b;
   logic [31:0] hi, lo, mf_data;
   logic        busy, done, stall;

   int n_checks = 0;
   int n_errors = 0;
   logic [63:0] sb_q[$];
   logic [63:0] sb_exp;

   muldiv_seq_unit #(.WIDTH(32), .OP_W(4), .FN_W(6), .RTYPE_OP(4'b1000)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .alu_op(alu_op), .fn_field(fn_field),
      .src_a(src_a), .src_b(src_b), .hi(hi), .lo(lo), .mf_data(mf_data),
      .busy(busy), .done(done), .stall(stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      longint sp;
      int     qa, qb;
      case (f)
         FN_MULT: begin
            sp = longint'($signed(a)) * longint'($signed(b));
            return sp;
         end
         FN_MULTU: return {32'h0, a} * {32'h0, b};
         FN_DIVU: begin
            if (b == 32'h0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
         FN_DIV: begin
            if (b == 32'h0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            qa = $signed(a);
            qb = $signed(b);
            return {32'(qa % qb), 32'(qa / qb)};
         end
         default: return 64'h0;
      endcase
   endfunction

   // Scoreboard: every done pulse must match the oldest issued operation.
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sb_q.size() == 0) begin
            check("spurious_done", {63'h0, done}, 64'h0);
         end else begin
            sb_exp = sb_q.pop_front();
            check("sb_hi", {32'h0, hi}, {32'h0, sb_exp[63:32]});
            check("sb_lo", {32'h0, lo}, {32'h0, sb_exp[31:0]});
         end
      end
   end

   task automatic do_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input string tag);
      int n;
      alu_op   = RT;
      fn_field = f;
      src_a    = a;
      src_b    = b;
      start    = 1'b1;
      sb_q.push_back(model(f, a, b));
      tick();
      start    = 1'b0;
      fn_field = FN_ADD;
      src_a    = $urandom;
      src_b    = $urandom;
      n = 0;
      while (!done && n < 100) begin
         tick();
         n++;
      end
      check({tag, "_latency"}, 64'(n), 64'd33);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] fns[4];
      int cyc;
      int n_done;
      fns = '{FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};

      rst_n = 1'b0; start = 1'b0; alu_op = 4'h0; fn_field = 6'h0; src_a = '0; src_b = '0;
      #2;
      check("rst_hi", {32'h0, hi}, 64'h0);
      check("rst_lo", {32'h0, lo}, 64'h0);
      check("rst_busy", {63'h0, busy}, 64'h0);
      check("rst_done", {63'h0, done}, 64'h0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      tick();

      // multu max*max with explicit busy/done timing
      alu_op = RT; fn_field = FN_MULTU; src_a = 32'hFFFF_FFFF; src_b = 32'hFFFF_FFFF; start = 1'b1;
      sb_q.push_back(model(FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
      tick();
      start = 1'b0; fn_field = FN_ADD;
      check("multu_busy_e0", {63'h0, busy}, 64'h1);
      for (int k = 1; k <= 32; k++) begin
         tick();
         check("multu_busy_calc", {63'h0, busy}, 64'h1);
         check("multu_done_early", {63'h0, done}, 64'h0);
      end
      tick();
      check("multu_busy_end", {63'h0, busy}, 64'h0);
      check("multu_done", {63'h0, done}, 64'h1);
      check("multu_hi", {32'h0, hi}, 64'hFFFF_FFFE);
      check("multu_lo", {32'h0, lo}, 64'h1);
      tick();
      check("multu_done_clear", {63'h0, done}, 64'h0);

      do_op(FN_MULT, 32'hFFFF_FFFD, 32'd5, "mult_neg");
      check("mult_hi", {32'h0, hi}, 64'hFFFF_FFFF);
      check("mult_lo", {32'h0, lo}, 64'hFFFF_FFF1);
      do_op(FN_DIVU, 32'd7, 32'd0, "divu_zero");
      check("divz_hi", {32'h0, hi}, 64'h7);
      check("divz_lo", {32'h0, lo}, 64'hFFFF_FFFF);
      do_op(FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
      check("ovf_hi", {32'h0, hi}, 64'h0);
      check("ovf_lo", {32'h0, lo}, 64'h8000_0000);
      // issued in the done cycle of the previous op
      do_op(FN_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg");
      check("div_hi", {32'h0, hi}, 64'hFFFF_FFFF);
      check("div_lo", {32'h0, lo}, 64'hFFFF_FFFD);

      // stall while busy; mf_data shows old hi; a second mult is ignored
      alu_op = RT; fn_field = FN_MULT; src_a = 32'h1234_5678; src_b = 32'h100; start = 1'b1;
      sb_q.push_back(model(FN_MULT, 32'h1234_5678, 32'h100));
      tick();
      start = 1'b0; fn_field = FN_ADD;
      cyc = 1;
      while (!done && cyc < 40) begin
         if (cyc >= 5) begin
            start = 1'b1;
            if (cyc == 10) begin
               fn_field = FN_MULT; src_a = 32'h7; src_b = 32'h9;
            end else begin
               fn_field = FN_MFHI;
            end
            #1;
            check("stall_busy", {63'h0, stall}, 64'h1);
            if (cyc != 10) check("mf_old_hi", {32'h0, mf_data}, 64'hFFFF_FFFF);
         end
         tick();
         cyc++;
      end
      check("stall_latency", 64'(cyc), 64'd34);
      start = 1'b1; fn_field = FN_MFHI;
      #1;
      check("stall_done_cycle", {63'h0, stall}, 64'h0);
      check("mf_new_hi", {32'h0, mf_data}, 64'h12);
      start = 1'b0; fn_field = FN_ADD;
      tick();

      // mthi / mtlo / mflo in IDLE
      alu_op = RT; fn_field = FN_MTHI; src_a = 32'h1234_5678; start = 1'b1;
      tick();
      start = 1'b0; fn_field = FN_ADD;
      check("mthi_hi", {32'h0, hi}, 64'h1234_5678);
      check("mthi_lo", {32'h0, lo}, 64'h3456_7800);
      check("mthi_busy", {63'h0, busy}, 64'h0);
      check("mthi_done", {63'h0, done}, 64'h0);
      start = 1'b1; fn_field = FN_MFLO;
      #1;
      check("mflo_data", {32'h0, mf_data}, 64'h3456_7800);
      check("mflo_stall", {63'h0, stall}, 64'h0);
      fn_field = FN_MTLO; src_a = 32'hCAFE_F00D;
      tick();
      start = 1'b0;
      check("mtlo_lo", {32'h0, lo}, 64'hCAFE_F00D);
      check("mtlo_hi", {32'h0, hi}, 64'h1234_5678);
      fn_field = FN_MFLO;
      #1;
      check("mflo_new", {32'h0, mf_data}, 64'hCAFE_F00D);
      fn_field = FN_ADD;
      #1;
      check("mf_nonmd", {32'h0, mf_data}, 64'h0);
      alu_op = 4'h0; fn_field = FN_MFHI;
      #1;
      check("mf_not_rtype", {32'h0, mf_data}, 64'h0);
      alu_op = RT;
      tick();

      for (int i = 0; i < 6; i++) begin
         logic [5:0] f;
         logic [31:0] a, b;
         f = fns[$urandom_range(0, 3)];
         a = $urandom;
         b = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000));
         do_op(f, a, b, "rand");
      end

      // asynchronous reset in the middle of a divide
      alu_op = RT; fn_field = FN_DIVU; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
      tick();
      start = 1'b0; fn_field = FN_ADD;
      repeat (9) tick();
      #3;
      rst_n = 1'b0;
      #1;
      check("abort_busy", {63'h0, busy}, 64'h0);
      check("abort_hi", {32'h0, hi}, 64'h0);
      check("abort_lo", {32'h0, lo}, 64'h0);
      check("abort_done", {63'h0, done}, 64'h0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      n_done = 0;
      repeat (40) begin
         tick();
         if (done) n_done++;
      end
      check("abort_no_done", 64'(n_done), 64'h0);
      do_op(FN_DIVU, 32'd100, 32'd7, "post_reset");
      check("post_lo", {32'h0, lo}, 64'd14);
      check("post_hi", {32'h0, hi}, 64'd2);
      tick();
      tick();
      check("sb_drained", 64'(sb_q.size()), 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
